// File: rtl/keypad_scanner_pkg.sv
// Shared types, constants and key-code helpers for the 4x4 keypad scanner.
package keypad_scanner_pkg;

   localparam int unsigned COLS    = 4;
   localparam int unsigned ROWS    = 4;
   localparam int unsigned FRAME_W = COLS * ROWS;

   localparam logic ST_IDLE    = 1'b0;
   localparam logic ST_PRESSED = 1'b1;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_SINGLE = 2'd1,
      CLS_MULTI  = 2'd2
   } frame_cls_e;

   // Debounced frame summary handed from the debouncer to the scanner FSM.
   typedef struct packed {
      logic               frame_done;
      logic               stable;
      frame_cls_e         cls;
      logic [FRAME_W-1:0] frame;
   } frame_info_t;

   function automatic logic [3:0] kp_code(input logic [1:0] r, input logic [1:0] c);
      return {r, c};
   endfunction

   // Frame bit 4c+r is row r seen while column c was driven; 0 means pressed.
   function automatic frame_cls_e classify(input logic [FRAME_W-1:0] f);
      logic [4:0] zeros;
      zeros = '0;
      for (int unsigned i = 0; i < FRAME_W; i++) begin
         zeros = zeros + {4'b0000, ~f[4'(i)]};
      end
      if (zeros == 5'd0) begin
         return CLS_NONE;
      end else if (zeros == 5'd1) begin
         return CLS_SINGLE;
      end
      return CLS_MULTI;
   endfunction

   function automatic logic [3:0] frame_code(input logic [FRAME_W-1:0] f);
      logic [3:0] code;
      code = '0;
      for (int unsigned c = 0; c < COLS; c++) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            if (!f[4'(c * ROWS + r)]) begin
               code = kp_code(2'(r), 2'(c));
            end
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// Assembles per-column row samples into frames and counts consecutive identical frames.
module kp_debounce
   import keypad_scanner_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        capture,
   input  logic [1:0]  col,
   input  logic [3:0]  rows_s,
   output frame_info_t info
);

   localparam int unsigned ST_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
   localparam logic [ST_W-1:0] ST_MAX = ST_W'(DEBOUNCE);

   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [FRAME_W-1:0] prev_q, prev_d;
   logic [ST_W-1:0]    stable_cnt_q, stable_cnt_d;
   logic               done_q, done_d;
   logic               stable_q, stable_d;
   frame_cls_e         cls_q, cls_d;
   logic [FRAME_W-1:0] new_frame;

   always_comb begin
      frame_d      = frame_q;
      prev_d       = prev_q;
      stable_cnt_d = stable_cnt_q;
      done_d       = 1'b0;
      stable_d     = stable_q;
      cls_d        = cls_q;
      new_frame    = frame_q;
      new_frame[{col, 2'b00} +: 4] = rows_s;
      if (capture) begin
         frame_d = new_frame;
         // Capturing the last column closes the frame.
         if (col == 2'(COLS - 1)) begin
            done_d = 1'b1;
            if (new_frame == prev_q) begin
               stable_cnt_d = (stable_cnt_q == ST_MAX) ? stable_cnt_q : stable_cnt_q + ST_W'(1);
            end else begin
               stable_cnt_d = '0;
            end
            prev_d   = new_frame;
            stable_d = (stable_cnt_d == ST_MAX);
            cls_d    = classify(new_frame);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q      <= '1;
         prev_q       <= '1;
         stable_cnt_q <= '0;
         done_q       <= 1'b0;
         stable_q     <= 1'b0;
         cls_q        <= CLS_NONE;
      end else begin
         frame_q      <= frame_d;
         prev_q       <= prev_d;
         stable_cnt_q <= stable_cnt_d;
         done_q       <= done_d;
         stable_q     <= stable_d;
         cls_q        <= cls_d;
      end
   end

   always_comb begin
      info.frame_done = done_q;
      info.stable     = stable_q;
      info.cls        = cls_q;
      info.frame      = prev_q;
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, press/release FSM and entry register.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        nReset,
   input  logic [3:0]  rows,
   input  logic        clr,
   output logic [3:0]  cols,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic [31:0] value,
   output logic        busy
);

   localparam int unsigned     CNT_W    = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [3:0]       rows_meta_q, rows_meta_d;
   logic [3:0]       rows_sync_q, rows_sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       col_q, col_d;
   logic [3:0]       cols_q, cols_d;
   logic             state_q, state_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic [31:0]      value_q, value_d;
   logic             busy_q, busy_d;
   logic             last_c;
   frame_info_t      info;

   // Synchroniser and column dwell/rotation.
   always_comb begin
      rows_meta_d = rows;
      rows_sync_d = rows_meta_q;
      last_c      = (cnt_q == CNT_LAST);
      cnt_d       = last_c ? '0 : cnt_q + CNT_W'(1);
      col_d       = last_c ? col_q + 2'd1 : col_q;
      cols_d      = ~(4'b0001 << col_d);
   end

   kp_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk     (clk),
      .rst_n   (nReset),
      .capture (last_c),
      .col     (col_q),
      .rows_s  (rows_sync_q),
      .info    (info)
   );

   // Press/release FSM; acts only on completed frames.
   always_comb begin
      state_d     = state_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      value_d     = value_q;
      case (state_q)
         ST_IDLE: begin
            if (info.frame_done && info.stable && info.cls == CLS_SINGLE) begin
               state_d     = ST_PRESSED;
               key_valid_d = 1'b1;
               key_code_d  = frame_code(info.frame);
               value_d     = {value_q[27:0], key_code_d};
            end
         end
         ST_PRESSED: begin
            if (info.frame_done && info.stable && info.cls == CLS_NONE) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A clear beats a simultaneous key entry.
      if (clr) begin
         value_d = '0;
      end
      busy_d = (state_d == ST_PRESSED);
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         rows_meta_q <= '1;
         rows_sync_q <= '1;
         cnt_q       <= '0;
         col_q       <= '0;
         cols_q      <= 4'b1110;
         state_q     <= ST_IDLE;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         value_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         rows_meta_q <= rows_meta_d;
         rows_sync_q <= rows_sync_d;
         cnt_q       <= cnt_d;
         col_q       <= col_d;
         cols_q      <= cols_d;
         state_q     <= state_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         value_q     <= value_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      cols      = cols_q;
      key_code  = key_code_q;
      key_valid = key_valid_q;
      value     = value_q;
      busy      = busy_q;
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised scoreboard bench for keypad_scanner with a frame-level behavioural keypad model.
module tb_keypad_scanner;

   localparam int SCAN_DIV  = 4;
   localparam int DEBOUNCE  = 2;
   localparam int FRAME_CYC = 4 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        nReset = 1'b0;
   logic [3:0]  rows;
   logic        clr = 1'b0;
   logic [3:0]  cols;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [31:0] value;
   logic        busy;

   // held[4c+r] = 1 while key (row r, column c) is pressed
   logic [15:0] held = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  code;
      logic [31:0] value;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   mon_events = 0;

   logic [15:0] m_prev = 16'hFFFF;
   int          m_stable = 0;
   bit          m_pressed = 1'b0;
   logic [31:0] m_value = '0;
   logic [3:0]  m_last = '0;
   int          m_events = 0;

   keypad_scanner #(
      .SCAN_DIV (SCAN_DIV),
      .DEBOUNCE (DEBOUNCE)
   ) dut (
      .clk       (clk),
      .nReset    (nReset),
      .rows      (rows),
      .clr       (clr),
      .cols      (cols),
      .key_code  (key_code),
      .key_valid (key_valid),
      .value     (value),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      rows = 4'hF;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (held[4'(c * 4 + r)] && !cols[2'(c)]) rows[2'(r)] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] key_bit(input int code);
      logic [15:0] one;
      one = 16'h0001;
      return one << (4 * (code % 4) + code / 4);
   endfunction

   // Monitor: every key_valid pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (nReset && key_valid) begin
         mon_events++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual code=%h value=%h required=no event t=%0t",
                     key_code, value, $time);
         end else begin
            mon_e = sb_q.pop_front();
            check("event_code", 32'(key_code), 32'(mon_e.code));
            check("event_value", value, mon_e.value);
         end
      end
   end

   // Frame-level reference: debounce count, press/release and entry register.
   task automatic model_frame(input logic [15:0] mask, input bit do_clr);
      logic [15:0] f;
      int          n;
      exp_t        e;
      f = ~mask;
      n = $countones(mask);
      if (f == m_prev) m_stable = (m_stable < DEBOUNCE) ? m_stable + 1 : DEBOUNCE;
      else m_stable = 0;
      m_prev = f;
      if (m_stable == DEBOUNCE) begin
         if (!m_pressed && n == 1) begin
            for (int i = 0; i < 16; i++) begin
               if (mask[4'(i)]) m_last = 4'((i % 4) * 4 + i / 4);
            end
            m_value   = {m_value[27:0], m_last};
            m_pressed = 1'b1;
            if (do_clr) m_value = '0;
            e.code  = m_last;
            e.value = m_value;
            sb_q.push_back(e);
            m_events++;
         end else if (m_pressed && n == 0) begin
            m_pressed = 1'b0;
         end
      end
      if (do_clr) m_value = '0;
   endtask

   // One full frame with a fixed set of held keys; called #1 after a frame boundary edge.
   task automatic run_frame(input logic [15:0] mask, input bit do_clr);
      logic [3:0] ec;
      held = mask;
      for (int k = 1; k <= FRAME_CYC; k++) begin
         @(posedge clk);
         #1;
         clr = 1'b0;
         ec  = ~(4'b0001 << 2'((k / SCAN_DIV) % 4));
         check("cols", 32'(cols), 32'(ec));
         if (k == 4) begin
            check("busy", 32'(busy), 32'(m_pressed));
            check("value", value, m_value);
            check("key_code_hold", 32'(key_code), 32'(m_last));
            check("key_valid_idle", 32'(key_valid), 32'd0);
            check("event_pending", 32'(sb_q.size()), 32'd0);
         end
      end
      model_frame(mask, do_clr);
      if (do_clr) clr = 1'b1;
   endtask

   task automatic run_frames(input logic [15:0] mask, input int n);
      for (int i = 0; i < n; i++) run_frame(mask, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cols"}, 32'(cols), 32'h0000000E);
      check({tag, "_key_code"}, 32'(key_code), 32'd0);
      check({tag, "_key_valid"}, 32'(key_valid), 32'd0);
      check({tag, "_value"}, value, 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Asynchronous reset asserted mid-frame, checked before any clock edge.
   task automatic reset_mid();
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2 nReset = 1'b0;
      #1 check_reset_outputs("async_reset");
      @(posedge clk);
      @(posedge clk);
      #1 nReset = 1'b1;
      m_prev    = 16'hFFFF;
      m_stable  = 0;
      m_pressed = 1'b0;
      m_value   = '0;
      m_last    = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] m;
      int          nf;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      nReset = 1'b1;

      run_frames('0, 3);

      run_frames(key_bit(6), 4);
      check("single_code", 32'(key_code), 32'h6);
      check("single_value", value, 32'h6);
      check("single_busy", 32'(busy), 32'd1);
      run_frames('0, 3);

      for (int d = 1; d <= 9; d++) begin
         run_frames(key_bit(d), 3);
         run_frames('0, 3);
      end
      check("overflow_value", value, 32'h23456789);

      for (int i = 0; i < 5; i++) run_frame((i % 2 == 0) ? key_bit(9) : 16'h0000, 1'b0);
      run_frames('0, 3);

      run_frames(key_bit(0) | key_bit(15), 4);
      run_frames('0, 3);

      run_frames(key_bit(1), 3);
      run_frames(key_bit(1) | key_bit(10), 4);
      run_frames('0, 3);

      run_frames(key_bit(15), 2);
      run_frame(key_bit(15), 1'b1);
      run_frame(key_bit(15), 1'b0);
      check("clr_collision_code", 32'(key_code), 32'hF);
      check("clr_collision_value", value, 32'd0);
      run_frames('0, 3);

      run_frames(key_bit(9), 4);
      reset_mid();
      run_frames(key_bit(9), 4);
      check("reaccept_code", 32'(key_code), 32'h9);
      check("reaccept_value", value, 32'h9);
      run_frames('0, 3);

      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 3))
            0: m = key_bit(int'($urandom_range(0, 15)));
            1: m = key_bit(int'($urandom_range(0, 15))) | key_bit(int'($urandom_range(0, 15)));
            2: m = '0;
            default: m = key_bit(int'($urandom_range(0, 15)));
         endcase
         nf = int'($urandom_range(1, 5));
         for (int f = 0; f < nf; f++) begin
            if ($urandom_range(0, 4) == 0) run_frame((f % 2 == 0) ? m : 16'h0000, 1'b0);
            else run_frame(m, $urandom_range(0, 7) == 0);
         end
      end
      run_frames('0, 3);

      check("final_pending", 32'(sb_q.size()), 32'd0);
      check("event_count", 32'(mon_events), 32'(m_events));
      check("final_value", value, m_value);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Board input block, the reading side of the board I/O: `multi_dt` writes digits out by scanning, and this block reads a 4x4 matrix keypad by scanning.
- Drives one keypad column low at a time and samples the active-low rows through a 2-flop synchroniser.
- Debounces whole-matrix frames, emits a one-cycle key event, and shifts each accepted hex nibble into a 32-bit entry register.
- The entry register feeds `main`'s DIn in place of, or muxed with, the switches.

Parameters:
- SCAN_DIV, 1000, clk cycles each column is held low (dwell); minimum 4.
- DEBOUNCE, 4, consecutive identical frames required to accept a press or a release; minimum 1.

Ports:
- clk  in  1  system clock.
- nReset  in  1  asynchronous active-low reset.
- rows  in  4  keypad row lines; active-low (pulled up externally); asynchronous to clk.
- clr  in  1  synchronous pulse that zeroes value.
- cols  out  4  keypad column drive; active-low one-hot.
- key_code  out  4  code of the last accepted key.
- key_valid  out  1  one-cycle pulse when a key is accepted.
- value  out  32  entered number; the most recent key is in the low nibble.
- busy  out  1  high while a key is held (state PRESSED).

Behaviour:
- Reset (async, nReset=0). All outputs and state return immediately to:
  - cols=4'b1110, key_code=0, key_valid=0, value=0, busy=0;
  - column index=0, dwell counter=0, stable counter=0, previous frame=16'hFFFF, state IDLE.
- Synchroniser: rows passes through 2 flops; only the synchronised copy is used anywhere.
- Column scan:
  - The dwell counter counts 0..SCAN_DIV-1.
  - On the last count, the synchronised rows are captured into frame bits [4c+3:4c], where c is the current column index.
  - The column index then advances c→c+1 mod 4, and cols = ~(1<<c).
- Frame completion:
  - A frame is complete when column 3 is captured, i.e. every 4*SCAN_DIV cycles.
  - The first frame completes 4*SCAN_DIV cycles after reset release.
- Frame debounce:
  - If the new frame equals the previous frame, stable = min(stable+1, DEBOUNCE); otherwise stable = 0.
  - The previous frame is then updated to the new frame.
  - A frame is "stable" when stable == DEBOUNCE after that update.
- Frame classification (pressed bit = 0):
  - NONE: no bits at 0.
  - SINGLE: exactly one bit at 0.
  - MULTI: two or more bits at 0.
- State machine, evaluated only at frame completion:
  - IDLE → PRESSED when the frame is stable and SINGLE.
    - Pressed bit at row r, column c gives code = {r[1:0], c[1:0]}.
    - In the next cycle: key_code=code, key_valid=1 for exactly one cycle, value={value[27:0], code}.
  - IDLE with a stable MULTI frame: ignored (ghosting); remain in IDLE with no event.
  - PRESSED → IDLE only on a stable NONE frame.
  - In PRESSED, SINGLE and MULTI frames are ignored, so there is no auto-repeat and pressing a second key while holding one produces no event.
- busy = (state == PRESSED).
- Latency: a clean press held from time t is accepted within (DEBOUNCE+2) frames + 3 cycles.
- value overflow: the top nibble is discarded on a shift; there is no saturation and no flag.
- clr:
  - When clr is asserted, value=0 in the next cycle.
  - If clr coincides with a key accept, clr wins: value=0, but key_valid still pulses and key_code still updates.
  - clr does not affect the scan, the debounce or the state machine.
- Reset asserted mid-dwell or mid-frame: all state clears asynchronously, and scanning restarts at column 0 on release.
- key_code holds its last value between events.

Decomposition:
- Shared package/header:
  - state encodings IDLE=0, PRESSED=1;
  - COLS=4, ROWS=4;
  - a function for the code mapping {r,c}.
- One sub-module, `kp_debounce`:
  - holds the frame register, the previous-frame compare and the stable counter;
  - outputs frame_done, stable and the classification.
- Top level: scan counter, synchroniser, FSM and value register.

Test Plan (SCAN_DIV=4, DEBOUNCE=2; the keypad model pulls row r low while col c is low and key (r,c) is held):
- Reset/idle: after reset with no key held, cols rotates 1110→1101→1011→0111 every 4 cycles; key_valid never pulses and value=0.
- Single press: hold key (1,2) → exactly one key_valid pulse with key_code=4'h6, value=32'h6, busy=1. Release → busy=0 after 2 stable NONE frames.
- Sequence and overflow: enter 1,2,3,4,5,6,7,8,9 → value=32'h23456789.
- Bounce and ghost rejection:
  - A press toggled every frame for 5 frames → no event.
  - Keys (0,0) and (3,3) held together from IDLE → no event.
  - Holding (0,1), then adding (2,2) → one event only, code 4'h1.
- clr collision: clr asserted in the same cycle as an accept of key F → key_valid=1, key_code=4'hF, value=0.
- Async reset mid-press: nReset pulsed low during PRESSED → outputs go to reset values immediately without a clock edge. With the key still held after release, it is accepted again after DEBOUNCE+1 frames.
